// File: rtl/router_fsm_pkg.sv
// Shared types and constants for the 1-to-3 router control FSM.
// State encoding is fixed at 3 bits with DECODE_ADDRESS at zero.
package router_fsm_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_0       = 2'd0;
  localparam logic [1:0] ADDR_1       = 2'd1;
  localparam logic [1:0] ADDR_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  // Picks the per-FIFO flag for an address; the invalid address selects nothing.
  function automatic logic addr_sel(input logic [1:0] addr,
                                    input logic f0, input logic f1, input logic f2);
    logic r;
    r = 1'b0;
    case (addr)
      ADDR_0:  r = f0;
      ADDR_1:  r = f1;
      ADDR_2:  r = f2;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: address decode, header/payload/parity sequencing,
// FIFO-full back-pressure and per-FIFO soft reset.
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       parity_done,
  input  logic [1:0] data_in,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       low_pkt_valid,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  output logic       busy,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       lfd_state
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       in_empty;
  logic       latched_empty;
  logic       soft_rst;

  // Reset input is active-high despite its name.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR_0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // DA decodes the live address; WTE and soft reset use the latched one.
  always_comb begin
    in_empty      = addr_sel(data_in, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    latched_empty = addr_sel(addr_q, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    soft_rst      = addr_sel(addr_q, soft_reset_0, soft_reset_1, soft_reset_2);

    addr_d = addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid)
      addr_d = data_in;

    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in != ADDR_INVALID)
          state_d = in_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (latched_empty) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    if (soft_rst)
      state_d = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    busy          = !(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: directed packet scenarios followed by
// random traffic, checked against a rule-level model of the router.
module tb_router_fsm;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn, pkt_valid, parity_done, fifo_full, low_pkt_valid;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [1:0] data_in;
  logic       busy, detect_add, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, lfd_state;
  logic [7:0] dut_out;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
    .parity_done(parity_done), .data_in(data_in),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .fifo_full(fifo_full),
    .low_pkt_valid(low_pkt_valid), .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .busy(busy), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg),
    .lfd_state(lfd_state)
  );

  assign dut_out = {busy, detect_add, ld_state, laf_state,
                    full_state, write_enb_reg, rst_int_reg, lfd_state};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } exp_t;
  exp_t sb_q[$];

  // Model state names deliberately use values unrelated to the RTL encoding.
  localparam int S_DA  = 11;
  localparam int S_LFD = 12;
  localparam int S_LD  = 13;
  localparam int S_LP  = 14;
  localparam int S_FFS = 15;
  localparam int S_LAF = 16;
  localparam int S_WTE = 17;
  localparam int S_CPE = 18;

  int m_state = S_DA;
  int m_addr  = 0;

  // Output vector: {busy, detect_add, ld, laf, full, write_enb, rst_int, lfd}.
  function automatic logic [7:0] model_out(input int s);
    case (s)
      S_DA:    return 8'b0100_0000;
      S_LFD:   return 8'b1000_0001;
      S_LD:    return 8'b0010_0100;
      S_LP:    return 8'b1000_0100;
      S_FFS:   return 8'b1000_1000;
      S_LAF:   return 8'b1001_0100;
      S_WTE:   return 8'b1000_0000;
      S_CPE:   return 8'b1000_0010;
      default: return 8'hxx;
    endcase
  endfunction

  // Apply the current inputs to the model for one clock and queue the result.
  task automatic step(input string tag);
    int   ns, na, din;
    logic empties [3];
    logic srs [3];
    exp_t e;
    empties[0] = fifo_empty_0; empties[1] = fifo_empty_1; empties[2] = fifo_empty_2;
    srs[0] = soft_reset_0; srs[1] = soft_reset_1; srs[2] = soft_reset_2;
    din = int'(data_in);
    if (resetn) begin
      ns = S_DA;
      na = 0;
    end else begin
      na = (m_state == S_DA && pkt_valid) ? din : m_addr;
      ns = m_state;
      case (m_state)
        S_DA:  if (pkt_valid && din < 3) ns = empties[din] ? S_LFD : S_WTE;
        S_LFD: ns = S_LD;
        S_LD:  ns = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
        S_FFS: ns = fifo_full ? S_FFS : S_LAF;
        S_LAF: ns = parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
        S_LP:  ns = S_CPE;
        S_CPE: ns = fifo_full ? S_FFS : S_DA;
        S_WTE: ns = (m_addr < 3 && empties[m_addr]) ? S_LFD : S_WTE;
        default: ns = S_DA;
      endcase
      if (m_addr < 3 && srs[m_addr]) ns = S_DA;
    end
    m_state = ns;
    m_addr  = na;
    e.exp = model_out(ns);
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic drive(input logic pv, input logic [1:0] din, input logic ff,
                       input logic lpv, input logic pd, input string tag);
    pkt_valid = pv; data_in = din; fifo_full = ff;
    low_pkt_valid = lpv; parity_done = pd;
    step(tag);
  endtask

  task automatic idle_inputs();
    resetn = 1'b0; pkt_valid = 1'b0; parity_done = 1'b0; data_in = 2'd0;
    fifo_full = 1'b0; low_pkt_valid = 1'b0;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
  endtask

  // Monitor: the DUT presents a fresh output vector after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dut_out !== e.exp) begin
          n_fail++;
          $display("FAIL %s at %0t: outputs got %b want %b", e.tag, $time, dut_out, e.exp);
        end
      end
    end
  end

  initial begin
    int budget;
    idle_inputs();
    resetn = 1'b1;
    @(negedge clock);
    step("reset");
    step("reset_hold");
    resetn = 1'b0;

    // Minimum packet to FIFO 0.
    drive(1, 2'd0, 0, 0, 0, "min_da_lfd");
    drive(0, 2'd0, 0, 0, 0, "min_lfd_ld");
    drive(0, 2'd0, 0, 0, 0, "min_ld_lp");
    drive(0, 2'd0, 0, 0, 0, "min_lp_cpe");
    drive(0, 2'd0, 0, 0, 0, "min_cpe_da");

    // Wait for FIFO 0 to drain.
    fifo_empty_0 = 1'b0;
    drive(1, 2'd0, 0, 0, 0, "wte_enter");
    fifo_empty_0 = 1'b1;
    drive(1, 2'd0, 0, 0, 0, "wte_lfd");
    drive(1, 2'd0, 0, 0, 0, "wte_ld");
    drive(0, 2'd0, 0, 0, 0, "wte_lp");
    drive(0, 2'd0, 0, 0, 0, "wte_cpe");
    drive(0, 2'd0, 0, 0, 0, "wte_da");

    // Full stall ending with low_pkt_valid.
    drive(1, 2'd2, 0, 0, 0, "ff_lfd");
    drive(1, 2'd2, 0, 0, 0, "ff_ld");
    drive(1, 2'd2, 1, 0, 0, "ff_ffs1");
    drive(1, 2'd2, 1, 0, 0, "ff_ffs2");
    drive(0, 2'd2, 0, 1, 0, "ff_laf");
    drive(0, 2'd2, 0, 1, 0, "ff_lp");
    drive(0, 2'd2, 0, 0, 0, "ff_cpe");
    drive(0, 2'd2, 0, 0, 0, "ff_da");

    // Full stall resuming payload, with full and !pkt_valid together in LD.
    drive(1, 2'd1, 0, 0, 0, "res_lfd");
    drive(1, 2'd1, 0, 0, 0, "res_ld");
    drive(0, 2'd1, 1, 0, 0, "res_full_prio");
    drive(1, 2'd1, 0, 0, 0, "res_laf");
    drive(1, 2'd1, 0, 0, 0, "res_ld_again");
    drive(0, 2'd1, 0, 0, 0, "res_lp");
    drive(0, 2'd1, 0, 0, 0, "res_cpe");
    drive(0, 2'd1, 0, 0, 0, "res_da");

    // Full during parity, released with parity_done.
    drive(1, 2'd0, 0, 0, 0, "par_lfd");
    drive(0, 2'd0, 0, 0, 0, "par_ld");
    drive(0, 2'd0, 0, 0, 0, "par_lp");
    drive(0, 2'd0, 1, 0, 0, "par_cpe");
    drive(0, 2'd0, 1, 0, 0, "par_ffs");
    drive(0, 2'd0, 0, 0, 1, "par_laf");
    drive(0, 2'd0, 0, 0, 1, "par_da");

    // Soft reset matching and non-matching the latched address.
    fifo_empty_1 = 1'b0;
    drive(1, 2'd1, 0, 0, 0, "sr_wte");
    soft_reset_0 = 1'b1;
    drive(0, 2'd0, 0, 0, 0, "sr_other_ignored");
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
    drive(0, 2'd0, 0, 0, 0, "sr_match_da");
    soft_reset_1 = 1'b0; fifo_empty_1 = 1'b1;
    drive(1, 2'd3, 0, 0, 0, "invalid_addr1");
    drive(1, 2'd3, 0, 0, 0, "invalid_addr2");
    drive(0, 2'd0, 0, 0, 0, "invalid_idle");

    // Reset in the middle of a packet.
    drive(1, 2'd2, 0, 0, 0, "mid_lfd");
    drive(1, 2'd2, 0, 0, 0, "mid_ld");
    resetn = 1'b1;
    drive(1, 2'd2, 0, 0, 0, "mid_reset");
    resetn = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      resetn        = ($urandom_range(0, 99) == 0);
      pkt_valid     = ($urandom_range(0, 9) < 7);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 9) < 3);
      low_pkt_valid = ($urandom_range(0, 1) == 1);
      parity_done   = ($urandom_range(0, 9) < 3);
      fifo_empty_0  = ($urandom_range(0, 9) < 6);
      fifo_empty_1  = ($urandom_range(0, 9) < 6);
      fifo_empty_2  = ($urandom_range(0, 9) < 6);
      soft_reset_0  = ($urandom_range(0, 99) < 3);
      soft_reset_1  = ($urandom_range(0, 99) < 3);
      soft_reset_2  = ($urandom_range(0, 99) < 3);
      step("random");
    end
    idle_inputs();

    budget = 0;
    while (sb_q.size() > 0 && budget < 10) begin
      @(negedge clock);
      budget++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending entries got %0d want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
# router_fsm

Control state machine for a 1-to-3 packet router. It decodes the 2-bit destination address of each incoming packet and waits until the addressed output FIFO is empty. It then sequences header, payload and parity loading, handles FIFO-full back-pressure, and triggers the parity check. It sits between the input synchronizer/FIFO-select logic and the register block that writes packet bytes into the three output FIFOs.

## Interface
- No parameters.
- clock  in  1  single clock domain; all state updates on rising edge.
- resetn  in  1  reset; synchronous and active-high (1 resets on the next rising edge, despite the name).
- pkt_valid  in  1  packet byte stream valid; falls after the last payload byte.
- parity_done  in  1  parity byte has been captured.
- data_in  in  2  destination address bits of the header byte (0,1,2 valid; 3 invalid).
- soft_reset_0/1/2  in  1 each  timeout soft reset of output FIFO 0/1/2.
- fifo_full  in  1  the currently selected FIFO is full.
- low_pkt_valid  in  1  the payload has ended while the FSM was stalled on full.
- fifo_empty_0/1/2  in  1 each  output FIFO n is empty.
- busy  out  1  the router cannot accept a new byte.
- detect_add  out  1  the FSM is in DECODE_ADDRESS.
- ld_state  out  1  the FSM is in LOAD_DATA.
- laf_state  out  1  the FSM is in LOAD_AFTER_FULL.
- full_state  out  1  the FSM is in FIFO_FULL_STATE.
- write_enb_reg  out  1  write enable for the FIFO data path.
- rst_int_reg  out  1  the FSM is in CHECK_PARITY_ERROR; resets internal parity registers.
- lfd_state  out  1  the FSM is in LOAD_FIRST_DATA (header byte).

## Operation
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE), CHECK_PARITY_ERROR (CPE).
- Address latch: a 2-bit register loads data_in on each clock while the FSM is in DA and pkt_valid=1. This register selects the fifo_empty_n and soft_reset_n used later.
- DA transitions:
  - pkt_valid=1, data_in=n (n in 0..2) and fifo_empty_n=1: go to LFD.
  - pkt_valid=1, data_in=n and fifo_empty_n=0: go to WTE.
  - Otherwise, including data_in=3: stay in DA.
- LFD: always go to LD.
- LD transitions:
  - fifo_full=1: go to FFS.
  - fifo_full=0 and pkt_valid=0: go to LP.
  - Otherwise: stay in LD.
- FFS: stay while fifo_full=1; otherwise go to LAF.
- LAF transitions (evaluated in this priority order):
  - parity_done=1: go to DA.
  - low_pkt_valid=1: go to LP.
  - Otherwise: go to LD.
- LP: always go to CPE.
- CPE: fifo_full=1 goes to FFS; otherwise go to DA.
- WTE: the latched address's fifo_empty=1 goes to LFD; otherwise stay in WTE.
- Soft reset: soft_reset_n=1 while the latched address equals n forces the next state to DA from any state. A soft reset for a non-matching FIFO is ignored.
- Priority: resetn > matching soft reset > normal transitions.
- Outputs are Moore outputs, decoded combinationally from the state register:
  - busy = LFD | LP | FFS | LAF | WTE | CPE. busy is 0 in DA and LD.
  - write_enb_reg = LD | LP | LAF.
  - detect_add, lfd_state, ld_state, laf_state, full_state and rst_int_reg are each asserted in exactly their own state.

## Timing
- Reset: state goes to DA and the address latch clears to 0. After reset, detect_add=1 and all other outputs are 0.
- Next-state decision uses inputs sampled at the rising edge. Outputs change in the same cycle as the state change (no extra register stage).
- Minimum packet path is DA→LFD→LD→LP→CPE→DA: header in 1 cycle, parity in 1 cycle, check in 1 cycle.
- A soft reset asserted for one cycle returns the FSM to DA on the next edge. A reset asserted mid-packet does the same, regardless of the current state.
- Simultaneous fifo_full=1 and pkt_valid=0 in LD: the FSM goes to FFS (full has priority).

## Structure
- A shared package holds the state enum (3-bit encoding, DA=0) and the address constants ADDR_0..ADDR_2 and ADDR_INVALID=3.
- The module has a single flat implementation: a state register, next-state logic and output decode. No sub-module is needed.

## Test plan
- Reset, then pkt_valid=1, data_in=0, fifo_empty_0=1, followed by pkt_valid=0 → DA→LFD→LD→LP→CPE→DA. lfd_state, ld_state and rst_int_reg each pulse for one cycle, and busy=0 in LD.
- pkt_valid=1, data_in=0, fifo_empty_0=0, then fifo_empty_0=1 one cycle later → DA→WTE→LFD→LD, with busy=1 in WTE.
- In LD, fifo_full=1 for 2 cycles, then fifo_full=0 with low_pkt_valid=1 → LD→FFS→FFS→LAF→LP→CPE→DA. full_state=1 in FFS, and write_enb_reg=1 in LAF.
- Same as the previous case but with low_pkt_valid=0 and parity_done=0 → LAF→LD; then pkt_valid=0 → LP→CPE→DA.
- In LP, fifo_full=1 → CPE→FFS. Release full with parity_done=1 → LAF→DA.
- Latch address 1 and sit in WTE:
  - soft_reset_0=1 leaves the FSM in WTE.
  - soft_reset_1=1 moves it to DA on the next edge.
  - data_in=3 with pkt_valid=1 keeps the FSM in DA.
